// File: rtl/bram_sdp_be.sv
// bram_sdp_be
// Simple-dual-port block RAM with per-byte write enables. It has one write port
// and one read port. Read data is registered and comes with a valid flag. An
// optional clear engine fills the array with CLEAR_VAL after every reset.
//
// Configuration macro: BRAM_CLEAR_EN
//   defined   - after reset, a counter/FSM writes CLEAR_VAL to every word, one
//               word per cycle. ready rises on the edge that writes word DEPTH-1.
//   undefined - there is no clear engine. ready rises on the first edge after
//               reset is released, and the array contents are uninitialised.
//
// Ports
//   clk     in   clock, all logic on the rising edge
//   resetb  in   asynchronous active-low reset
//   ready   out  high when the RAM accepts accesses
//   we      in   write request
//   be      in   byte enables, bit i covers di[8i+7:8i]
//   waddr   in   write address
//   di      in   write data
//   re      in   read request
//   raddr   in   read address
//   dout    out  registered read data
//   rvalid  out  dout was updated by a read accepted on the previous edge
//
// Parameters
//   RDW_MODE selects the same-address read-during-write policy:
//     0 = the read returns the merged new word
//     1 = the read returns the old word
//   Addresses >= DEPTH drop writes and read back as zero.

module bram_sdp_be #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned DEPTH_LOG = 8,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RDW_MODE  = 0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                   clk,
    input  logic                   resetb,
    output logic                   ready,
    input  logic                   we,
    input  logic [WIDTH/8-1:0]     be,
    input  logic [DEPTH_LOG-1:0]   waddr,
    input  logic [WIDTH-1:0]       di,
    input  logic                   re,
    input  logic [DEPTH_LOG-1:0]   raddr,
    output logic [WIDTH-1:0]       dout,
    output logic                   rvalid
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 clr_we;
    logic [DEPTH_LOG-1:0] clr_addr;

    logic                 waddr_ok;
    logic                 raddr_ok;
    logic                 acc_we;
    logic                 acc_re;

    logic                 mem_we;
    logic [DEPTH_LOG-1:0] mem_addr;
    logic [NB-1:0]        mem_be;
    logic [WIDTH-1:0]     mem_wdata;

    logic [WIDTH-1:0]     rd_word;
    logic [WIDTH-1:0]     do_d, do_q;
    logic                 rvalid_d, rvalid_q;

`ifdef BRAM_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t               state_d, state_q;
    logic [DEPTH_LOG-1:0] cnt_d, cnt_q;

    // The clear engine owns the write port for exactly DEPTH cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + DEPTH_LOG'(1);
                if (32'(cnt_q) == DEPTH - 1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RUN is entered on the same edge that writes the last word.
    assign ready = (state_q == ST_RUN);
`else
    logic ready_d, ready_q;

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign ready_d  = 1'b1;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
`endif

    // Accesses are only taken in RUN. Out-of-range writes are dropped here.
    always_comb begin
        waddr_ok  = (32'(waddr) < DEPTH);
        raddr_ok  = (32'(raddr) < DEPTH);
        acc_we    = ready & we & waddr_ok;
        acc_re    = ready & re;
        mem_we    = clr_we | acc_we;
        mem_addr  = clr_we ? clr_addr : waddr;
        mem_be    = clr_we ? {NB{1'b1}} : be;
        mem_wdata = clr_we ? CLEAR_VAL : di;
    end

    // The array has no reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // In write-first mode, a same-address write forwards its enabled bytes
    // into the read result. Otherwise the read sees the pre-edge word.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem[raddr];
        end
        if (RDW_MODE == 0 && acc_we && waddr == raddr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    rd_word[8*i +: 8] = di[8*i +: 8];
                end
            end
        end
        do_d     = do_q;
        rvalid_d = 1'b0;
        if (acc_re) begin
            do_d     = rd_word;
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            do_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            do_q     <= do_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign dout   = do_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_bram_sdp_be.sv
// tb_bram_sdp_be
// This bench drives two RAMs from the same stimulus:
//   u0: DEPTH=16, RDW_MODE=0 (write-first)
//   u1: DEPTH=12, RDW_MODE=1 (read-first); addresses 12..15 are out of range
// Each read request pushes the expected word for each RAM into a queue. A monitor
// pops one entry each time that RAM shows rvalid and compares it.

module tb_bram_sdp_be;

    localparam logic [31:0] CV = 32'hDEADBEEF;
`ifdef BRAM_CLEAR_EN
    localparam int EXP_RDY0 = 16;
    localparam int EXP_RDY1 = 12;
`else
    localparam int EXP_RDY0 = 1;
    localparam int EXP_RDY1 = 1;
`endif

    logic        clk = 1'b0;
    logic        resetb;
    logic        we, re;
    logic [3:0]  be, waddr, raddr;
    logic [31:0] di;
    logic        ready0, ready1, rvalid0, rvalid1;
    logic [31:0] dout0, dout1;

    int errors = 0;
    int checks = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    string       n0[$];
    string       n1[$];

    bram_sdp_be #(.DEPTH(16), .DEPTH_LOG(4), .WIDTH(32), .RDW_MODE(0), .CLEAR_VAL(CV)) u0 (
        .clk(clk), .resetb(resetb), .ready(ready0), .we(we), .be(be), .waddr(waddr),
        .di(di), .re(re), .raddr(raddr), .dout(dout0), .rvalid(rvalid0));

    bram_sdp_be #(.DEPTH(12), .DEPTH_LOG(4), .WIDTH(32), .RDW_MODE(1), .CLEAR_VAL(CV)) u1 (
        .clk(clk), .resetb(resetb), .ready(ready1), .we(we), .be(be), .waddr(waddr),
        .di(di), .re(re), .raddr(raddr), .dout(dout1), .rvalid(rvalid1));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge. For reads, also queue the
    // expected result of each RAM.
    task automatic applyStimulus(input logic iwe, input logic [3:0] ibe, input logic [3:0] iwa,
                                 input logic [31:0] idi, input logic ire, input logic [3:0] ira,
                                 input logic [31:0] e0, input logic [31:0] e1, input string name);
        @(negedge clk);
        we    = iwe;
        be    = ibe;
        waddr = iwa;
        di    = idi;
        re    = ire;
        raddr = ira;
        if (ire) begin
            q0.push_back(e0);
            n0.push_back({name, "_u0"});
            q1.push_back(e1);
            n1.push_back({name, "_u1"});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "");
        end
    endtask

    // Release reset, count the edges until each ready rises, and drop the gated
    // access after the first edge.
    task automatic measureReady(input string name);
        int r0 = -1;
        int r1 = -1;
        @(negedge clk);
        resetb = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                we = 1'b0;
                re = 1'b0;
            end
            if (r0 < 0 && ready0 === 1'b1) r0 = c;
            if (r1 < 0 && ready1 === 1'b1) r1 = c;
            if (r0 >= 0 && r1 >= 0) break;
        end
        checkOutput({name, "_ready_cycles_u0"}, 32'(r0), 32'(EXP_RDY0));
        checkOutput({name, "_ready_cycles_u1"}, 32'(r1), 32'(EXP_RDY1));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_dout_u0"},   dout0, 32'h0);
        checkOutput({name, "_dout_u1"},   dout1, 32'h0);
        checkOutput({name, "_rvalid_u0"}, 32'(rvalid0), 32'h0);
        checkOutput({name, "_rvalid_u1"}, 32'(rvalid1), 32'h0);
        checkOutput({name, "_ready_u0"},  32'(ready0), 32'h0);
        checkOutput({name, "_ready_u1"},  32'(ready1), 32'h0);
    endtask

    task automatic setGatedAccess();
        we    = 1'b1;
        be    = 4'hF;
        waddr = 4'd3;
        di    = 32'h12345678;
        re    = 1'b1;
        raddr = 4'd3;
    endtask

    function automatic logic [31:0] tdat(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h0001_0101;
    endfunction

    // Scoreboard monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid_u0: got rvalid=1 dout=%h expected no read", dout0);
            end else begin
                checkOutput(n0.pop_front(), dout0, q0.pop_front());
            end
        end
        if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid_u1: got rvalid=1 dout=%h expected no read", dout1);
            end else begin
                checkOutput(n1.pop_front(), dout1, q1.pop_front());
            end
        end
    end

    initial begin
        resetb = 1'b0;
        we = 1'b0; re = 1'b0; be = 4'h0; waddr = 4'h0; raddr = 4'h0; di = 32'h0;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");

        // Accesses issued while ready is low must be ignored.
        setGatedAccess();
        measureReady("clear1");

`ifndef BRAM_CLEAR_EN
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 4'hF, 4'(a), CV, 1'b0, 4'h0, 32'h0, 32'h0, "");
        end
`endif
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), CV, (a < 12) ? CV : 32'h0, "clear_read");
        end

        // Byte enables.
        applyStimulus(1'b1, 4'b1111, 4'd5, 32'h11223344, 1'b0, 4'd0, 32'h0, 32'h0, "");
        applyStimulus(1'b1, 4'b0101, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0, 32'h0, 32'h0, "");
        applyStimulus(1'b1, 4'b0000, 4'd2, 32'h00000000, 1'b1, 4'd5, 32'h11BB33DD, 32'h11BB33DD, "be_merge");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, CV, CV, "be_zero");

        // Read-during-write on the same address.
        applyStimulus(1'b1, 4'b1111, 4'd7, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, "");
        applyStimulus(1'b1, 4'b0011, 4'd7, 32'hFFFFFFFF, 1'b1, 4'd7, 32'h0000FFFF, 32'h00000000, "rdw");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h0000FFFF, 32'h0000FFFF, "rdw_after");

        // Out of range applies to u1 only; addresses 0..11 are untouched.
        applyStimulus(1'b1, 4'hF, 4'd13, 32'h5, 1'b0, 4'd0, 32'h0, 32'h0, "");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd13, 32'h5, 32'h0, "oor_read");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0, CV, CV, "oor_addr0");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd11, CV, CV, "oor_addr11");

        // Throughput: write addr k and read addr k-1 on every cycle.
        applyStimulus(1'b1, 4'hF, 4'd0, tdat(0), 1'b0, 4'd0, 32'h0, 32'h0, "");
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b1, 4'hF, 4'(k % 16), tdat(k), 1'b1, 4'((k - 1) % 16),
                          tdat(k - 1), (((k - 1) % 16) < 12) ? tdat(k - 1) : 32'h0, "stream");
        end
        idle(2);

        // Reset during RUN clears the outputs immediately.
        @(posedge clk);
        #3 resetb = 1'b0;
        #1 checkResetOutputs("reset_run");

        // Reset again in the middle of the clear (counter at 9).
        @(negedge clk);
        resetb = 1'b1;
        repeat (9) @(posedge clk);
        #3 resetb = 1'b0;
        #1 checkResetOutputs("reset_midclear");
        setGatedAccess();
        measureReady("clear2");

`ifdef BRAM_CLEAR_EN
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd4, CV, CV, "reclear_addr4");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, CV, CV, "reclear_addr3");
`else
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd4, tdat(100), tdat(100), "keep_addr4");
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, tdat(99), tdat(99), "keep_addr3");
`endif
        idle(3);

        checkOutput("pending_reads_u0", 32'(q0.size()), 32'h0);
        checkOutput("pending_reads_u1", 32'(q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
